// File: rtl/rs_cdb_wakeup_pkg.sv
// Shared types for the CDB-snooping reservation station: entry layouts, tag width,
// dispatch/CDB lane count, and the tag-match helper used for wakeup and bypass.
package rs_cdb_wakeup_pkg;
    localparam int N          = 3;
    localparam int PHYS_TAG_W = 6;
    localparam int PAYLOAD_W  = 16;

    typedef struct packed {
        logic [PHYS_TAG_W-1:0] dest_tag;
        logic [PHYS_TAG_W-1:0] src1_tag;
        logic                  src1_ready;
        logic [PHYS_TAG_W-1:0] src2_tag;
        logic                  src2_ready;
        logic [PAYLOAD_W-1:0]  payload;
    } RS_ENTRY;

    typedef struct packed {
        logic                  valid;
        logic [PHYS_TAG_W-1:0] tags;
    } CDB_ENTRY;

    function automatic logic tag_hit(input logic [PHYS_TAG_W-1:0] tag,
                                     input CDB_ENTRY [N-1:0]      cdb);
        tag_hit = 1'b0;
        for (int l = 0; l < N; l++) begin
            if (cdb[l].valid && (cdb[l].tags == tag)) begin
                tag_hit = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/rs_cdb_wakeup_if.sv
// Dispatch, CDB snoop and issue handshake bundle of the reservation station;
// master is the upstream/FU side, slave is the station itself.
interface rs_cdb_wakeup_if import rs_cdb_wakeup_pkg::*; #(
    parameter int DEPTH = 8
);
    localparam int FC_W = $clog2(DEPTH + 1);

    logic     [N-1:0]    disp_valid;
    RS_ENTRY  [N-1:0]    disp_entry;
    CDB_ENTRY [N-1:0]    cdb_input;
    logic                squash;
    logic     [FC_W-1:0] free_count;
    logic                issue_valid;
    RS_ENTRY             issue_entry;
    logic                issue_ready;
    logic                overflow;

    modport master (
        output disp_valid, disp_entry, cdb_input, squash, issue_ready,
        input  free_count, issue_valid, issue_entry, overflow
    );

    modport slave (
        input  disp_valid, disp_entry, cdb_input, squash, issue_ready,
        output free_count, issue_valid, issue_entry, overflow
    );
endinterface

// File: rtl/psel_gen.sv
// Priority selector: grant k is the k-th lowest set bit of req (zero when fewer exist).
// Purely combinational, zero latency; no flow control.
module psel_gen #(
    parameter int WIDTH = 8,
    parameter int REQS  = 1
) (
    input  logic [WIDTH-1:0]            req,
    output logic [REQS-1:0][WIDTH-1:0]  gnt_bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] rem;

    always_comb begin
        rem     = req;
        gnt_bus = '0;
        for (int r = 0; r < REQS; r++) begin
            gnt_bus[r] = rem & ~(rem - ONE);
            rem        = rem & ~gnt_bus[r];
        end
    end
endmodule

// File: rtl/rs_cdb_wakeup.sv
// Reservation station: N-wide dispatch, N-lane CDB wakeup, one valid/ready issue per cycle.
// Dispatch/wakeup take effect next cycle; presentation may move to a lower slot while issue_ready is low.
module rs_cdb_wakeup import rs_cdb_wakeup_pkg::*; #(
    parameter int DEPTH = 8
) (
    input logic            clock,
    input logic            reset,
    rs_cdb_wakeup_if.slave rs
);
    localparam int FC_W = $clog2(DEPTH + 1);

    logic    [DEPTH-1:0]        busy, busy_n;
    RS_ENTRY [DEPTH-1:0]        slot, slot_n;
    logic    [N-1:0][DEPTH-1:0] alloc_gnt;
    logic    [N-1:0][DEPTH-1:0] lane_gnt;
    logic    [0:0][DEPTH-1:0]   issue_gnt;
    logic    [DEPTH-1:0]        cand;
    logic    [FC_W-1:0]         free_cnt, n_valid;
    RS_ENTRY                    issue_sel;
    logic                       overflow_q, issue_fire;

    psel_gen #(.WIDTH(DEPTH), .REQS(N)) u_alloc_sel (.req(~busy), .gnt_bus(alloc_gnt));
    psel_gen #(.WIDTH(DEPTH), .REQS(1)) u_issue_sel (.req(cand),  .gnt_bus(issue_gnt));

    always_comb begin
        free_cnt = FC_W'(DEPTH);
        cand     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_cnt = free_cnt - FC_W'(busy[i]);
            cand[i]  = busy[i] & slot[i].src1_ready & slot[i].src2_ready;
        end
    end

    always_comb begin
        issue_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_gnt[0][i]) issue_sel = slot[i];
        end
    end

    assign rs.issue_valid = (|cand) & ~rs.squash;
    assign rs.issue_entry = issue_sel;
    assign rs.free_count  = free_cnt;
    assign rs.overflow    = overflow_q;
    assign issue_fire     = rs.issue_valid & rs.issue_ready;

    // Valid lanes take grants in order; lanes ranked past the free count get an empty grant.
    always_comb begin
        int rank;
        rank     = 0;
        lane_gnt = '0;
        for (int k = 0; k < N; k++) begin
            if (rs.disp_valid[k]) begin
                lane_gnt[k] = alloc_gnt[rank];
                rank++;
            end
        end
        n_valid = FC_W'(rank);
    end

    always_comb begin
        busy_n = busy;
        slot_n = slot;
        for (int s = 0; s < DEPTH; s++) begin
            if (busy[s]) begin
                slot_n[s].src1_ready = slot[s].src1_ready | tag_hit(slot[s].src1_tag, rs.cdb_input);
                slot_n[s].src2_ready = slot[s].src2_ready | tag_hit(slot[s].src2_tag, rs.cdb_input);
            end
        end
        if (issue_fire) busy_n = busy_n & ~issue_gnt[0];
        // Allocation only ever targets slots free before this edge, so it never meets the issued slot.
        for (int k = 0; k < N; k++) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (lane_gnt[k][s]) begin
                    slot_n[s]            = rs.disp_entry[k];
                    slot_n[s].src1_ready = rs.disp_entry[k].src1_ready
                                         | tag_hit(rs.disp_entry[k].src1_tag, rs.cdb_input);
                    slot_n[s].src2_ready = rs.disp_entry[k].src2_ready
                                         | tag_hit(rs.disp_entry[k].src2_tag, rs.cdb_input);
                    busy_n[s]            = 1'b1;
                end
            end
        end
        if (rs.squash) busy_n = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            slot       <= '0;
            overflow_q <= 1'b0;
        end else begin
            busy       <= busy_n;
            slot       <= slot_n;
            overflow_q <= overflow_q | (n_valid > free_cnt);
        end
    end
endmodule

// File: tb/tb_rs_cdb_wakeup.sv
// Directed bench for rs_cdb_wakeup: a vector table plus hand-built overflow, squash
// and mid-cycle reset sequences; outputs are sampled 1 time unit after each falling edge.
module tb_rs_cdb_wakeup;
    import rs_cdb_wakeup_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic     [N-1:0] dv;
        RS_ENTRY  [N-1:0] de;
        CDB_ENTRY [N-1:0] cdb;
        logic             sq;
        logic             ir;
        int               ef;
        logic             eiv;
        RS_ENTRY          eie;
        logic             eo;
    } vec_t;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
    RS_ENTRY Z;
    vec_t tbl[$];

    rs_cdb_wakeup_if #(.DEPTH(DEPTH)) rsif ();

    rs_cdb_wakeup #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .rs    (rsif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic RS_ENTRY mk(input int d, input int s1, input logic r1, input int s2, input logic r2);
        RS_ENTRY e;
        e.dest_tag   = PHYS_TAG_W'(d);
        e.src1_tag   = PHYS_TAG_W'(s1);
        e.src1_ready = r1;
        e.src2_tag   = PHYS_TAG_W'(s2);
        e.src2_ready = r2;
        e.payload    = {10'h2A5, PHYS_TAG_W'(d)};
        return e;
    endfunction

    function automatic RS_ENTRY rdy(input int d);
        return mk(d, 0, 1'b1, 0, 1'b1);
    endfunction

    function automatic RS_ENTRY nrdy(input int d);
        return mk(d, 50, 1'b0, 0, 1'b1);
    endfunction

    function automatic vec_t mkv(input logic [N-1:0] dv, input RS_ENTRY e0, input RS_ENTRY e1,
                                 input RS_ENTRY e2, input int cl, input int ct, input logic sq,
                                 input logic ir, input int ef, input logic eiv, input RS_ENTRY eie,
                                 input logic eo);
        vec_t v;
        v.dv    = dv;
        v.de[0] = e0;
        v.de[1] = e1;
        v.de[2] = e2;
        for (int l = 0; l < N; l++) begin
            v.cdb[l].tags  = PHYS_TAG_W'(ct);
            v.cdb[l].valid = (l == cl);
        end
        v.sq  = sq;
        v.ir  = ir;
        v.ef  = ef;
        v.eiv = eiv;
        v.eie = eie;
        v.eo  = eo;
        return v;
    endfunction

    function automatic vec_t idle(input logic ir, input int ef, input logic eiv, input RS_ENTRY eie, input logic eo);
        return mkv('0, '0, '0, '0, -1, 0, 1'b0, ir, ef, eiv, eie, eo);
    endfunction

    function automatic vec_t bc(input int cl, input int ct, input logic ir, input int ef,
                                input logic eiv, input RS_ENTRY eie, input logic eo);
        return mkv('0, '0, '0, '0, cl, ct, 1'b0, ir, ef, eiv, eie, eo);
    endfunction

    task automatic check(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    task automatic drive_idle();
        rsif.disp_valid  = '0;
        rsif.disp_entry  = '0;
        rsif.cdb_input   = '0;
        rsif.squash      = 1'b0;
        rsif.issue_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        @(negedge clock);
        rsif.disp_valid  = v.dv;
        rsif.disp_entry  = v.de;
        rsif.cdb_input   = v.cdb;
        rsif.squash      = v.sq;
        rsif.issue_ready = v.ir;
        #1;
        check("free_count",  id, 64'(rsif.free_count),  64'(v.ef));
        check("issue_valid", id, 64'(rsif.issue_valid), 64'(v.eiv));
        check("overflow",    id, 64'(rsif.overflow),    64'(v.eo));
        if (!v.sq) check("issue_entry", id, 64'(rsif.issue_entry), 64'(v.eie));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Z      = '0;
        reset  = 1'b0;
        drive_idle();

        // Reset state, basic issue, delayed wakeup, bypass, src2 wakeup, preemption.
        tbl.push_back(idle(0, 8, 0, Z, 0));
        tbl.push_back(mkv(3'b111, rdy(1), rdy(2), rdy(3), -1, 0, 0, 0, 8, 0, Z, 0));
        tbl.push_back(idle(0, 5, 1, rdy(1), 0));
        tbl.push_back(idle(1, 5, 1, rdy(1), 0));
        tbl.push_back(idle(1, 6, 1, rdy(2), 0));
        tbl.push_back(idle(1, 7, 1, rdy(3), 0));
        tbl.push_back(mkv(3'b001, mk(4, 12, 0, 0, 1), Z, Z, -1, 0, 0, 1, 8, 0, Z, 0));
        tbl.push_back(idle(0, 7, 0, Z, 0));
        tbl.push_back(bc(2, 12, 0, 7, 0, Z, 0));
        tbl.push_back(idle(0, 7, 1, mk(4, 12, 1, 0, 1), 0));
        tbl.push_back(idle(1, 7, 1, mk(4, 12, 1, 0, 1), 0));
        tbl.push_back(mkv(3'b010, Z, mk(5, 12, 0, 0, 1), Z, 0, 12, 0, 0, 8, 0, Z, 0));
        tbl.push_back(idle(0, 7, 1, mk(5, 12, 1, 0, 1), 0));
        tbl.push_back(idle(1, 7, 1, mk(5, 12, 1, 0, 1), 0));
        tbl.push_back(mkv(3'b001, mk(6, 0, 1, 33, 0), Z, Z, -1, 33, 0, 0, 8, 0, Z, 0));
        tbl.push_back(bc(-1, 33, 0, 7, 0, Z, 0));
        tbl.push_back(bc(0, 33, 0, 7, 0, Z, 0));
        tbl.push_back(idle(1, 7, 1, mk(6, 0, 1, 33, 1), 0));
        tbl.push_back(mkv(3'b011, mk(7, 40, 0, 0, 1), rdy(8), Z, -1, 0, 0, 0, 8, 0, Z, 0));
        tbl.push_back(bc(1, 40, 0, 6, 1, rdy(8), 0));
        tbl.push_back(idle(0, 6, 1, mk(7, 40, 1, 0, 1), 0));
        tbl.push_back(idle(1, 6, 1, mk(7, 40, 1, 0, 1), 0));
        tbl.push_back(idle(1, 7, 1, rdy(8), 0));
        tbl.push_back(idle(0, 8, 0, Z, 0));

        repeat (2) @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Held presentation: slot 0 stays put for four cycles without issue_ready.
        run_vec(mkv(3'b011, rdy(9), rdy(10), Z, -1, 0, 0, 0, 8, 0, Z, 0), 100);
        for (int c = 0; c < 4; c++) run_vec(idle(0, 6, 1, rdy(9), 0), 101 + c);
        run_vec(idle(1, 6, 1, rdy(9), 0), 105);
        run_vec(idle(0, 7, 1, rdy(10), 0), 106);
        run_vec(idle(1, 7, 1, rdy(10), 0), 107);
        run_vec(idle(0, 8, 0, Z, 0), 108);

        // Overflow: fill to one free slot, then offer three lanes.
        run_vec(mkv(3'b111, nrdy(11), nrdy(12), nrdy(13), -1, 0, 0, 0, 8, 0, Z, 0), 200);
        run_vec(mkv(3'b111, nrdy(14), nrdy(15), nrdy(16), -1, 0, 0, 0, 5, 0, Z, 0), 201);
        run_vec(mkv(3'b001, nrdy(17), Z, Z, -1, 0, 0, 0, 2, 0, Z, 0), 202);
        run_vec(mkv(3'b111, rdy(30), rdy(31), rdy(32), -1, 0, 0, 0, 1, 0, Z, 0), 203);
        run_vec(idle(0, 0, 1, rdy(30), 1), 204);
        run_vec(idle(0, 0, 1, rdy(30), 1), 205);

        // Squash on a full station, then on six busy entries with dispatch and issue_ready.
        run_vec(mkv('0, Z, Z, Z, -1, 0, 1, 1, 0, 0, Z, 1), 300);
        run_vec(idle(0, 8, 0, Z, 1), 301);
        run_vec(mkv(3'b111, nrdy(40), nrdy(41), nrdy(42), -1, 0, 0, 0, 8, 0, Z, 1), 302);
        run_vec(mkv(3'b111, nrdy(43), nrdy(44), rdy(45), -1, 0, 0, 0, 5, 0, Z, 1), 303);
        run_vec(idle(0, 2, 1, rdy(45), 1), 304);
        run_vec(mkv(3'b011, rdy(46), rdy(47), Z, -1, 0, 1, 1, 2, 0, Z, 1), 305);
        run_vec(idle(0, 8, 0, Z, 1), 306);

        // Asynchronous reset between clock edges.
        run_vec(mkv(3'b011, rdy(50), rdy(51), Z, -1, 0, 0, 0, 8, 0, Z, 1), 400);
        run_vec(idle(0, 6, 1, rdy(50), 1), 401);
        @(negedge clock);
        drive_idle();
        #2 reset = 1'b0;
        #1;
        check("async_free_count",  402, 64'(rsif.free_count),  64'(DEPTH));
        check("async_issue_valid", 402, 64'(rsif.issue_valid), 64'(0));
        check("async_issue_entry", 402, 64'(rsif.issue_entry), 64'(0));
        check("async_overflow",    402, 64'(rsif.overflow),    64'(0));
        @(negedge clock);
        reset = 1'b1;
        run_vec(idle(0, 8, 0, Z, 0), 403);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rs_cdb_wakeup.md
# rs_cdb_wakeup

Reservation station that sits on the receiving end of the CDB. It accepts up to `N` dispatched instructions per cycle and snoops all `N` CDB lanes every cycle, waking source operands whose physical tags match. It issues one fully-ready instruction per cycle to its functional unit over a valid/ready handshake. Its completed results later re-enter the CDB arbiter through that FU's output.

## Interface
- `DEPTH`, default 8: entry count, power of two ≥ `N`.
- `N`, default `` `N ``: dispatch width and CDB lane count.
- `clock`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `disp_valid`, input, `N`: per-lane dispatch request.
- `disp_entry`, input, `RS_ENTRY [N]`: dispatched instructions. Each carries `dest_tag`, `src1_tag`, `src1_ready`, `src2_tag`, `src2_ready`, `payload`.
- `cdb_input`, input, `CDB_ENTRY [N]`: registered CDB broadcast. Only `valid` and `tags` are used.
- `squash`, input, 1: flush all entries.
- `free_count`, output, `$clog2(DEPTH+1)`: free slots, computed from registered state only.
- `issue_valid`, output, 1: an issuable entry is presented.
- `issue_entry`, output, `RS_ENTRY`: the entry presented.
- `issue_ready`, input, 1: FU accepts the entry this cycle.
- `overflow`, output, 1: sticky protocol-error flag.

## Operation
- Per slot state: `busy`, `RS_ENTRY`.
- Reset (async, `reset`=0):
  - all `busy`=0
  - `free_count`=`DEPTH`
  - `issue_valid`=0
  - `issue_entry`='0
  - `overflow`=0
- Allocation:
  - Valid dispatch lanes are packed in ascending lane order into free slots, lowest index first.
  - Selection uses `psel_gen` (REQS=`N`) over `~busy`.
- Protocol: upstream must not present more valid lanes than `free_count`. On violation, the excess highest-indexed lanes are dropped and `overflow` sets. `overflow` clears only on reset.
- Wakeup:
  - For each busy slot and each CDB lane with `valid`=1, a `tags` match on `srcX_tag` sets `srcX_ready`.
  - Multiple matching lanes are benign.
  - CDB-to-dispatch bypass: a lane dispatched in the same cycle as a matching broadcast is written with that ready bit already set.
- Issue select:
  - Candidate = `busy && src1_ready && src2_ready` (registered state).
  - The lowest-index candidate is presented.
  - `issue_valid` = any candidate.
  - `issue_entry` = the candidate's contents, or '0 when there is no candidate.
- Handshake:
  - On `issue_valid && issue_ready`, the presented slot's `busy` clears at the next edge.
  - Without `issue_ready`, the same entry stays presented unless a lower-index entry becomes ready, in which case the presentation moves to it. Downstream must not assume stability.
- Squash:
  - Highest priority. Next state: all `busy`=0, and dispatch lanes in that cycle are discarded.
  - `issue_valid` is forced 0 during a squash cycle; no issue completes.
- Freed slots are not reusable in the cycle they are freed.

## Timing
- Dispatch at edge t: the entry is visible in `free_count` and eligible for issue from cycle t+1, if both operands are ready.
- CDB broadcast in cycle t: the dependent entry can present `issue_valid` in cycle t+1, giving one-cycle wakeup-to-issue.
- `free_count` is updated one cycle after dispatch, issue, or squash.
- `issue_valid` and `issue_entry` are combinational from registers; there is no input-to-output combinational path except `squash`→`issue_valid`.
- Simultaneous dispatch + issue + wakeup in one cycle: all three take effect at the same edge, and there is no slot conflict because allocation uses pre-edge `busy`.
- Reset asserted mid-operation: state clears immediately (async); outputs take reset values within the same cycle.

## Structure
- `RS_ENTRY` and `CDB_ENTRY` typedefs and `` `N `` live in `sys_defs.svh`. `PHYS_TAG_W` is a shared constant.
- Reuse `psel_gen`: one instance (REQS=`N`) for allocation and one instance (REQS=1) for issue select.
- Wakeup compare logic stays inline. No new sub-module is needed.

## Test plan
- Reset → `free_count`=8, `issue_valid`=0, `overflow`=0. Dispatch 3 ready entries → `free_count`=5 next cycle and `issue_valid`=1 with slot 0 presented.
- Dispatch entry with `src1_tag`=12 not ready. CDB lane 2 broadcasts tag 12 two cycles later → `issue_valid`=1 exactly one cycle after the broadcast.
- Dispatch tag-12 dependent in the same cycle CDB broadcasts 12 → entry stored with `src1_ready`=1, issuable next cycle.
- Hold `issue_ready`=0 for 4 cycles with 2 ready entries → slot 0 held, `free_count` unchanged. Then assert `issue_ready` → slot 0 freed, slot 1 presented.
- Fill to `free_count`=1, dispatch 3 lanes → only lane 0 stored, `overflow`=1 and it stays set.
- Assert `squash` with 6 busy entries, `issue_ready`=1, and 2 dispatch lanes → `issue_valid`=0 that cycle, `free_count`=8 next cycle.
